// File: rtl/hs_fifo.sv
// hs_fifo: synchronous FIFO with valid/ready handshake on both sides.
// The head entry is visible on out_data as soon as it is stored. Any depth
// of 2 or more is supported. The block also reports a live occupancy count,
// programmable almost-full and almost-empty flags, and a synchronous flush.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   flush                  synchronous clear of all contents
//   in_data/in_valid       producer side, in_ready = slot free and not flushing
//   out_data/out_valid     head of queue (zero when not valid)
//   out_ready              consumer takes head this cycle
//   count                  stored entries
//   almost_full            count >= AF_LEVEL
//   almost_empty           count <= AE_LEVEL
module hs_fifo #(
  parameter int D_SIZE   = 64,
  parameter int F_SIZE   = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1,
  localparam int unsigned C_BITS = $clog2(F_SIZE + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [D_SIZE-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [D_SIZE-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [C_BITS-1:0] count,
  output logic              almost_full,
  output logic              almost_empty
);

  localparam int unsigned P_BITS = $clog2(F_SIZE);

  // Reject unusable parameterisations at elaboration
  if (F_SIZE < 2) begin : g_chk_depth
    $error("hs_fifo: F_SIZE must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > F_SIZE) begin : g_chk_af
    $error("hs_fifo: AF_LEVEL must be within 1..F_SIZE");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > F_SIZE - 1) begin : g_chk_ae
    $error("hs_fifo: AE_LEVEL must be within 0..F_SIZE-1");
  end

  logic [D_SIZE-1:0] mem [F_SIZE];

  logic [P_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [P_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [C_BITS-1:0] count_q, count_d;
  logic              wr_fire, rd_fire;

  // Handshake qualifiers; flush masks both sides in the same cycle
  always_comb begin
    in_ready  = (count_q != C_BITS'(F_SIZE)) && !flush;
    out_valid = (count_q != '0) && !flush;
    wr_fire   = in_valid && in_ready;
    rd_fire   = out_valid && out_ready;
  end

  // Next pointer/count; pointers wrap explicitly so any depth works
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_d = (wr_ptr_q == P_BITS'(F_SIZE - 1)) ? '0 : wr_ptr_q + P_BITS'(1);
      end
      if (rd_fire) begin
        rd_ptr_d = (rd_ptr_q == P_BITS'(F_SIZE - 1)) ? '0 : rd_ptr_q + P_BITS'(1);
      end
      if (wr_fire && !rd_fire) begin
        count_d = count_q + C_BITS'(1);
      end else if (rd_fire && !wr_fire) begin
        count_d = count_q - C_BITS'(1);
      end
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_fire && rst_n) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  // Head data is forced to zero when nothing valid is presented
  always_comb begin
    out_data     = out_valid ? mem[rd_ptr_q] : '0;
    count        = count_q;
    almost_full  = count_q >= C_BITS'(AF_LEVEL);
    almost_empty = count_q <= C_BITS'(AE_LEVEL);
  end

endmodule

// File: tb/tb_hs_fifo.sv
// tb_hs_fifo: directed bench for hs_fifo (D_SIZE=8, F_SIZE=5, AF=4, AE=1).
module tb_hs_fifo;

  localparam int D = 8;
  localparam int F = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;
  logic       almost_full;
  logic       almost_empty;

  int n_checks = 0;
  int n_err    = 0;

  hs_fifo #(.D_SIZE(D), .F_SIZE(F), .AF_LEVEL(4), .AE_LEVEL(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, then let outputs settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] nxt;

    rst_n = 1'b0; flush = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    #3;
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_af", 32'(almost_full), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Write latency: visible after the accepting edge, not before
    in_data = 8'hA5; in_valid = 1'b1; #1;
    chk("lat_pre_valid", 32'(out_valid), 0);
    tick();
    in_valid = 1'b0; #1;
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_data", 32'(out_data), 32'h A5);
    chk("lat_count", 32'(count), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; #1;
    chk("lat_drained", 32'(count), 0);

    // Fill to full without reading
    for (int i = 1; i <= 5; i++) begin
      in_data = 8'(i * 'h11); in_valid = 1'b1;
      tick();
      if (i == 3) begin
        chk("fill3_af", 32'(almost_full), 0);
        chk("fill3_ae", 32'(almost_empty), 0);
      end
      if (i == 4) chk("fill4_af", 32'(almost_full), 1);
    end
    in_data = 8'h66; #1;
    chk("full_count", 32'(count), 5);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_af", 32'(almost_full), 1);
    tick();
    chk("full_hold_count", 32'(count), 5);
    chk("full_head", 32'(out_data), 32'h11);
    // A read at full does not open in_ready in the same cycle
    out_ready = 1'b1; #1;
    chk("full_no_comb", 32'(in_ready), 0);
    tick();
    out_ready = 1'b0; #1;
    chk("full_rd_count", 32'(count), 4);
    chk("full_rd_head", 32'(out_data), 32'h22);
    chk("slot_free", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0; #1;
    chk("x66_accepted", 32'(count), 5);
    out_ready = 1'b1;
    for (int i = 2; i <= 6; i++) begin
      #1;
      chk("drain_data", 32'(out_data), 32'(i * 'h11));
      tick();
    end
    out_ready = 1'b0; #1;
    chk("drain_count", 32'(count), 0);
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_zero_data", 32'(out_data), 0);

    // Interleaved fill/drain across the pointer wrap
    nxt = 8'h01;
    for (int i = 1; i <= 12; i++) begin
      in_data = 8'(i); in_valid = 1'b1; out_ready = (i > 2); #1;
      if (i > 2) begin
        chk("wrap_data", 32'(out_data), 32'(nxt));
        nxt++;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("wrap_tail", 32'(out_data), 32'(nxt));
      nxt++;
      tick();
    end
    out_ready = 1'b0; #1;
    chk("wrap_empty", 32'(count), 0);

    // Steady-state simultaneous read/write at count=3
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(8'h31 + i);
      tick();
    end
    chk("ss_start", 32'(count), 3);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'(8'h40 + i); #1;
      chk("ss_data", 32'(out_data), (i < 3) ? 32'(8'h31 + i) : 32'(8'h40 + i - 3));
      tick();
      chk("ss_count", 32'(count), 3);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ss_tail", 32'(out_data), 32'(8'h47 + i));
      tick();
    end
    // Empty with both sides active: only the write happens
    in_valid = 1'b1; in_data = 8'h50;
    tick();
    chk("empty_wr_only", 32'(count), 1);
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_data = 8'(8'h50 + i);
      tick();
    end
    chk("refill", 32'(count), 5);
    // Full with both sides active: only the read happens
    in_data = 8'h55; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_valid = 1'b0; #1;
    chk("full_rd_only", 32'(count), 4);
    chk("full_rd_head2", 32'(out_data), 32'h51);

    // Flush beats both handshakes
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 8'h77; #1;
    chk("fl_in_ready", 32'(in_ready), 0);
    chk("fl_out_valid", 32'(out_valid), 0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; #1;
    chk("fl_count", 32'(count), 0);
    chk("fl_data", 32'(out_data), 0);
    chk("fl_ae", 32'(almost_empty), 1);
    in_data = 8'h99; in_valid = 1'b1; #1;
    chk("fl_ready", 32'(in_ready), 1);
    tick();
    chk("post_fl_count", 32'(count), 1);
    chk("post_fl_data", 32'(out_data), 32'h99);

    // Asynchronous reset mid-stream
    in_data = 8'hBB;
    tick();
    chk("pre_rst_count", 32'(count), 2);
    rst_n = 1'b0; #1;
    chk("ar_count", 32'(count), 0);
    chk("ar_out_valid", 32'(out_valid), 0);
    chk("ar_out_data", 32'(out_data), 0);
    chk("ar_in_ready", 32'(in_ready), 1);
    chk("ar_ae", 32'(almost_empty), 1);
    chk("ar_af", 32'(almost_full), 0);
    tick();
    chk("ar_no_write", 32'(count), 0);
    rst_n = 1'b1; in_data = 8'hCC;
    tick();
    in_valid = 1'b0; #1;
    chk("ar_after_count", 32'(count), 1);
    chk("ar_after_data", 32'(out_data), 32'hCC);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
